// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side blocks.
//   UART_DW     - width of one UART data byte.
//   tx_state_e  - states of the byte-issue sequencer in uart_tx_sched.
package uart_pkg;

  localparam int unsigned UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE,     // ready to issue a byte once the transmitter is free
    WAIT_HI,  // byte issued, waiting for the transmitter to report busy
    WAIT_LO,  // frame in flight, waiting for the transmitter to finish
    GAP       // programmable idle time before the next issue
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin priority selector.
//   req_i    - request vector, one bit per requester.
//   ptr_i    - index of the most recent winner; priority starts at ptr_i+1.
//   valid_o  - at least one request is active.
//   winner_o - index of the first active request at or after ptr_i+1,
//              wrapping from N-1 to 0. Zero when valid_o is low.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);

  int unsigned idx;

  // Scan from the lowest-priority slot (ptr itself) towards the highest
  // (ptr+1); the last hit overwrites earlier ones, so the nearest wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin packet scheduler feeding one 8N1 UART
// transmitter from NREQ byte-stream clients.
//   clk, rst   - clock, asynchronous active-high reset.
//   req_valid  - client i offers a byte (held until its req_ack).
//   req_data   - byte of client i in bits [8i+7:8i].
//   req_last   - offered byte ends the client's packet.
//   req_ack    - one-cycle pulse: client i's byte was taken.
//   tx_data    - byte presented to the transmitter.
//   tx_start   - one-cycle start pulse to the transmitter.
//   tx_busy    - transmitter busy, rises the cycle after tx_start.
//   grant_id   - client currently (or most recently) granted.
//   locked     - a multi-byte packet is in progress for grant_id.
//   tmo_err    - one-cycle pulse when a stalled packet lock is revoked.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned GAP_CLKS = 0,
  parameter int unsigned LOCK_TMO = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [UART_DW*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_ack,
  output logic [UART_DW-1:0]         tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       locked,
  output logic                       tmo_err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [15:0] GAP_LAST = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;
  localparam logic [15:0] TMO_LAST = 16'(LOCK_TMO - 1);

  tx_state_e            state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic                 locked_q, locked_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [UART_DW-1:0]   data_q, data_d;
  logic                 start_q, start_d;
  logic                 tmo_q, tmo_d;
  logic [15:0]          gap_q, gap_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;

  logic [NREQ-1:0]      arb_req;
  logic                 arb_valid;
  logic [IW-1:0]        arb_win;

  // While a packet is locked only the granted client may compete, so the
  // arbiter returns either grant_q or nothing.
  assign arb_req = locked_q ? (req_valid & (NREQ'(1) << grant_q)) : req_valid;

  rr_arbiter #(
    .N (NREQ),
    .W (IW)
  ) u_arb (
    .req_i    (arb_req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_win)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold/pulse default before the
    // case statement; any path that skipped an assignment would infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    data_d    = data_q;
    gap_d     = gap_q;
    tmo_cnt_d = tmo_cnt_q;
    ack_d     = '0;
    start_d   = 1'b0;
    tmo_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stalled lock: the granted client has gone quiet mid-packet.
        if (locked_q && !req_valid[grant_q]) begin
          if (tmo_cnt_q == TMO_LAST) begin
            locked_d  = 1'b0;
            tmo_d     = 1'b1;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end
        if (!tx_busy && arb_valid) begin
          grant_d          = arb_win;
          ptr_d            = arb_win;
          data_d           = req_data[int'(arb_win)*UART_DW +: UART_DW];
          start_d          = 1'b1;
          ack_d[arb_win]   = 1'b1;
          locked_d         = ~req_last[arb_win];
          tmo_cnt_d        = '0;
          state_d          = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (GAP_CLKS > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      grant_q   <= '0;
      locked_q  <= 1'b0;
      ack_q     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      tmo_q     <= 1'b0;
      gap_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      locked_q  <= locked_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      start_q   <= start_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign req_ack  = ack_q;
  assign tx_data  = data_q;
  assign tx_start = start_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;
  assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scoreboard bench for uart_tx_sched.
// Instance A: GAP_CLKS=0, LOCK_TMO=20. Instance B: GAP_CLKS=10.
// Each instance has a small transmitter model (busy for BUSY_LEN cycles,
// rising the cycle after tx_start). Expected (client, byte) pairs are queued
// when stimulus is issued; a monitor pops one per tx_start.
module tb_uart_tx_sched;

  localparam int NREQ     = 4;
  localparam int BUSY_LEN = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   a_valid, a_last, a_ack;
  logic [8*NREQ-1:0] a_data;
  logic [7:0]        a_tx_data;
  logic              a_tx_start, a_tx_busy, a_locked, a_tmo;
  logic [1:0]        a_grant;

  logic [NREQ-1:0]   b_valid, b_last, b_ack;
  logic [8*NREQ-1:0] b_data;
  logic [7:0]        b_tx_data;
  logic              b_tx_start, b_tx_busy, b_locked, b_tmo;
  logic [1:0]        b_grant;

  uart_tx_sched #(.NREQ(NREQ), .GAP_CLKS(0), .LOCK_TMO(20)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data),
    .req_last(a_last), .req_ack(a_ack), .tx_data(a_tx_data),
    .tx_start(a_tx_start), .tx_busy(a_tx_busy), .grant_id(a_grant),
    .locked(a_locked), .tmo_err(a_tmo)
  );

  uart_tx_sched #(.NREQ(NREQ), .GAP_CLKS(10)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
    .req_last(b_last), .req_ack(b_ack), .tx_data(b_tx_data),
    .tx_start(b_tx_start), .tx_busy(b_tx_busy), .grant_id(b_grant),
    .locked(b_locked), .tmo_err(b_tmo)
  );

  // Transmitter models: not reset by rst, a frame in flight keeps going.
  int bcnt_a = 0;
  int bcnt_b = 0;
  always @(posedge clk) begin
    if (a_tx_start)      bcnt_a <= BUSY_LEN;
    else if (bcnt_a > 0) bcnt_a <= bcnt_a - 1;
    if (b_tx_start)      bcnt_b <= BUSY_LEN;
    else if (bcnt_b > 0) bcnt_b <= bcnt_b - 1;
  end
  assign a_tx_busy = (bcnt_a != 0);
  assign b_tx_busy = (bcnt_b != 0);

  typedef struct packed { logic last; logic [7:0] data; } byte_t;
  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;

  byte_t cq_a[NREQ][$];
  byte_t cq_b[$];
  exp_t  exp_a[$];
  exp_t  exp_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input bit sel_b, input int which);
    case (which)
      0:       return sel_b ? b_tx_start : a_tx_start;
      1:       return sel_b ? b_tx_busy  : a_tx_busy;
      default: return sel_b ? b_tmo      : a_tmo;
    endcase
  endfunction

  // Waits (at least one negedge) until the chosen signal equals val.
  task automatic wait_sig(input bit sel_b, input int which, input logic val,
                          input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (sig(sel_b, which) !== val && cycles < 300);
    if (sig(sel_b, which) !== val) check({tag, "_wait"}, 32'(sig(sel_b, which)), 32'(val));
  endtask

  function automatic bit a_drained();
    for (int i = 0; i < NREQ; i++) if (cq_a[i].size() != 0) return 1'b0;
    return (exp_a.size() == 0) && !a_tx_busy && !a_tx_start;
  endfunction

  task automatic wait_idle(input bit sel_b, input string tag);
    int k = 0;
    while (k < 400 && !(sel_b ? (cq_b.size() == 0 && exp_b.size() == 0 && !b_tx_busy)
                              : a_drained())) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drained"}, 32'(k < 400), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Client driver: pops the byte acked at the previous edge, presents the next.
  task automatic drive_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (a_ack[i] && cq_a[i].size() > 0) void'(cq_a[i].pop_front());
        if (cq_a[i].size() > 0) begin
          a_valid[i] = 1'b1;
          a_data[8*i +: 8] = cq_a[i][0].data;
          a_last[i] = cq_a[i][0].last;
        end else begin
          a_valid[i] = 1'b0;
          a_data[8*i +: 8] = 8'h00;
          a_last[i] = 1'b0;
        end
      end
      if (b_ack[0] && cq_b.size() > 0) void'(cq_b.pop_front());
      b_valid = {3'b000, cq_b.size() > 0};
      b_data  = {24'h0, (cq_b.size() > 0) ? cq_b[0].data : 8'h00};
      b_last  = {3'b000, (cq_b.size() > 0) ? cq_b[0].last : 1'b0};
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_tx_start) begin
        check("a_start_width", 32'(a_prev), 32'd0);
        if (exp_a.size() == 0) begin
          check("a_unexpected_start", 32'(exp_a.size()), 32'd1);
        end else begin
          e = exp_a.pop_front();
          check("a_tx_data", 32'(a_tx_data), 32'(e.data));
          check("a_grant_id", 32'(a_grant), 32'(e.id));
          check("a_req_ack", 32'(a_ack), 32'd1 << e.id);
        end
      end
      if (b_tx_start) begin
        check("b_start_width", 32'(b_prev), 32'd0);
        if (exp_b.size() == 0) begin
          check("b_unexpected_start", 32'(exp_b.size()), 32'd1);
        end else begin
          e = exp_b.pop_front();
          check("b_tx_data", 32'(b_tx_data), 32'(e.data));
          check("b_grant_id", 32'(b_grant), 32'(e.id));
          check("b_req_ack", 32'(b_ack), 32'd1 << e.id);
        end
      end
      a_prev = a_tx_start;
      b_prev = b_tx_start;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int viol;
    a_valid = '0; a_data = '0; a_last = '0;
    b_valid = '0; b_data = '0; b_last = '0;
    fork
      drive_loop();
      monitor_loop();
    join_none

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_req_ack",  32'(a_ack),      32'd0);
    check("rst_tx_data",  32'(a_tx_data),  32'd0);
    check("rst_tx_start", 32'(a_tx_start), 32'd0);
    check("rst_grant_id", 32'(a_grant),    32'd0);
    check("rst_locked",   32'(a_locked),   32'd0);
    check("rst_tmo_err",  32'(a_tmo),      32'd0);

    // Contention from reset: clients 0,1,2 single-byte packets, twice.
    cq_a[0].push_back('{1'b1, 8'h10});
    cq_a[1].push_back('{1'b1, 8'h11});
    cq_a[2].push_back('{1'b1, 8'h12});
    exp_a.push_back('{2'd0, 8'h10});
    exp_a.push_back('{2'd1, 8'h11});
    exp_a.push_back('{2'd2, 8'h12});
    rst = 1'b0;
    wait_idle(1'b0, "contention1");
    cq_a[0].push_back('{1'b1, 8'h20});
    cq_a[1].push_back('{1'b1, 8'h21});
    cq_a[2].push_back('{1'b1, 8'h22});
    exp_a.push_back('{2'd0, 8'h20});
    exp_a.push_back('{2'd1, 8'h21});
    exp_a.push_back('{2'd2, 8'h22});
    wait_idle(1'b0, "contention2");

    // Single client packet 0x55,0xAA; gap measured from the first edge that
    // samples tx_busy low to the edge that raises tx_start.
    cq_a[0].push_back('{1'b0, 8'h55});
    cq_a[0].push_back('{1'b1, 8'hAA});
    exp_a.push_back('{2'd0, 8'h55});
    exp_a.push_back('{2'd0, 8'hAA});
    wait_sig(1'b0, 0, 1'b1, "single_start1", c);
    check("single_locked_mid", 32'(a_locked), 32'd1);
    wait_sig(1'b0, 1, 1'b1, "single_busy_hi", c);
    wait_sig(1'b0, 1, 1'b0, "single_busy_lo", c);
    wait_sig(1'b0, 0, 1'b1, "single_start2", c);
    check("gap0_cycles", 32'(c - 1), 32'd1);
    check("single_locked_end", 32'(a_locked), 32'd0);
    wait_idle(1'b0, "single");

    // Packet lock: client 1 three bytes while client 0 stays valid.
    cq_a[1].push_back('{1'b0, 8'h01});
    cq_a[1].push_back('{1'b0, 8'h02});
    cq_a[1].push_back('{1'b1, 8'h03});
    cq_a[0].push_back('{1'b1, 8'h40});
    exp_a.push_back('{2'd1, 8'h01});
    exp_a.push_back('{2'd1, 8'h02});
    exp_a.push_back('{2'd1, 8'h03});
    exp_a.push_back('{2'd0, 8'h40});
    wait_idle(1'b0, "pktlock");

    // Lock timeout: client 2 stalls after a non-last byte, client 3 waits.
    cq_a[2].push_back('{1'b0, 8'h81});
    cq_a[3].push_back('{1'b1, 8'h93});
    exp_a.push_back('{2'd2, 8'h81});
    exp_a.push_back('{2'd3, 8'h93});
    wait_sig(1'b0, 0, 1'b1, "tmo_start", c);
    check("tmo_locked_mid", 32'(a_locked), 32'd1);
    wait_sig(1'b0, 1, 1'b1, "tmo_busy_hi", c);
    wait_sig(1'b0, 1, 1'b0, "tmo_busy_lo", c);
    wait_sig(1'b0, 2, 1'b1, "tmo_pulse", c);
    check("tmo_cycles", 32'(c - 1), 32'd20);
    check("tmo_unlocked", 32'(a_locked), 32'd0);
    @(negedge clk);
    check("tmo_pulse_width", 32'(a_tmo), 32'd0);
    wait_idle(1'b0, "tmo");

    // Reset while in WAIT_LO of a locked packet.
    cq_a[2].push_back('{1'b0, 8'hE1});
    cq_a[2].push_back('{1'b1, 8'hE2});
    exp_a.push_back('{2'd2, 8'hE1});
    wait_sig(1'b0, 0, 1'b1, "rstmid_start", c);
    check("rstmid_locked_pre", 32'(a_locked), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cq_a[1].push_back('{1'b1, 8'h3C});
    exp_a.push_back('{2'd1, 8'h3C});
    exp_a.push_back('{2'd2, 8'hE2});
    #1;
    check("rstmid_req_ack",  32'(a_ack),      32'd0);
    check("rstmid_tx_data",  32'(a_tx_data),  32'd0);
    check("rstmid_tx_start", 32'(a_tx_start), 32'd0);
    check("rstmid_grant_id", 32'(a_grant),    32'd0);
    check("rstmid_locked",   32'(a_locked),   32'd0);
    check("rstmid_tmo_err",  32'(a_tmo),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int k = 0; k < 50 && a_tx_busy; k++) begin
      @(negedge clk);
      if (a_tx_start && a_tx_busy) viol++;
    end
    check("rstmid_no_start_while_busy", 32'(viol), 32'd0);
    wait_idle(1'b0, "rstmid");

    // Gap of 10 on instance B.
    cq_b.push_back('{1'b0, 8'hC3});
    cq_b.push_back('{1'b1, 8'h3C});
    exp_b.push_back('{2'd0, 8'hC3});
    exp_b.push_back('{2'd0, 8'h3C});
    wait_sig(1'b1, 0, 1'b1, "gap10_start1", c);
    check("gap10_locked_mid", 32'(b_locked), 32'd1);
    wait_sig(1'b1, 1, 1'b1, "gap10_busy_hi", c);
    wait_sig(1'b1, 1, 1'b0, "gap10_busy_lo", c);
    wait_sig(1'b1, 0, 1'b1, "gap10_start2", c);
    check("gap10_cycles", 32'(c - 1), 32'd11);
    wait_idle(1'b1, "gap10");

    check("a_exp_left", 32'(exp_a.size()), 32'd0);
    check("b_exp_left", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
